uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receiver.
- Takes the receiver's byte-complete strobe and byte, and stores one entry per completed byte in a circular FIFO.
- Presents bytes to the system side with a valid/ready handshake, so a slow consumer does not lose characters.
- Tracks fill level and flags a sticky overflow when a byte arrives while the buffer is full.

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side buffer that sits directly after a UART receiver. Each rising
//   edge of the receiver's byte-complete strobe stores one byte in a circular
//   FIFO. Bytes are handed to the system side with a first-word fall-through
//   valid/ready interface. The block also reports the fill level and keeps a
//   sticky overflow flag for bytes dropped while the buffer was full.
//
// Handshake: o_valid/o_data describe the head entry. An entry is consumed at
//   a rising i_clk edge where o_valid & i_ready. o_valid does not depend on
//   i_ready. Asserting i_ready while o_valid is low has no effect.
//
// Ports
//   i_clk           system clock
//   i_reset         asynchronous, active-high reset
//   i_wr            byte-complete strobe (from a divided clock, any length)
//   i_data          received byte, stable while i_wr is high
//   o_valid         head entry present
//   o_data          head entry, zero while empty
//   i_ready         consumer accepts head entry
//   o_count         number of stored entries, 0..DEPTH
//   o_full          o_count == DEPTH
//   o_overflow      sticky: a byte arrived while full and was dropped
//   i_clr_overflow  synchronous clear of o_overflow (a new drop wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_overflow,
  input  logic                  i_clr_overflow
);

  // i_wr synchroniser (s1, s2) plus the edge-detect history flop (s3).
  // All three reset to 1 so a strobe held high across reset release is not
  // mistaken for a new byte.
  logic wr_s1_q, wr_s2_q, wr_s3_q;

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic do_write;
  logic drop;

  assign push = wr_s2_q & ~wr_s3_q;
  assign full = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign pop  = (count_q != '0) & i_ready;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when the head is being consumed.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (pop) begin
      head_d = head_q + ADDR_WIDTH'(1);
    end
    if (do_write) begin
      tail_d = tail_q + ADDR_WIDTH'(1);
    end

    case ({do_write, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear.
    if (i_clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_s1_q    <= 1'b1;
      wr_s2_q    <= 1'b1;
      wr_s3_q    <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_s1_q    <= i_wr;
      wr_s2_q    <= wr_s1_q;
      wr_s3_q    <= wr_s2_q;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; stale contents are never visible because
  // o_data is forced to zero whenever the count is zero.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      mem_q[tail_q] <= i_data;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_data     = o_valid ? mem_q[head_q] : '0;
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo (DATA_WIDTH=8, DEPTH=16). Inputs change
//   on the falling clock edge; outputs are sampled on the falling edge.
//   exp_q holds the bytes the FIFO should contain, in order.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          wr;
  logic [DW-1:0] wdata;
  logic          valid;
  logic [DW-1:0] rdata;
  logic          ready;
  logic [AW:0]   count;
  logic          full;
  logic          ovf;
  logic          clr_ovf;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_wr           (wr),
    .i_data         (wdata),
    .o_valid        (valid),
    .o_data         (rdata),
    .i_ready        (ready),
    .o_count        (count),
    .o_full         (full),
    .o_overflow     (ovf),
    .i_clr_overflow (clr_ovf)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_vectors;
  int n_miscompares;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full strobe: rising edge of i_wr is written at the third clock edge,
  // then i_wr is low long enough for the edge detector to re-arm.
  task automatic push_byte(input logic [DW-1:0] b);
    wr    = 1'b1;
    wdata = b;
    repeat (3) @(negedge clk);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag);
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    check_val({tag, " valid"}, 32'(valid), 32'd1);
    check_val({tag, " data"},  32'(rdata), 32'(e));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst     = 1'b1;
    wr      = 1'b0;
    wdata   = '0;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_val("rst valid", 32'(valid), 32'd0);
    check_val("rst count", 32'(count), 32'd0);
    check_val("rst full",  32'(full),  32'd0);
    check_val("rst ovf",   32'(ovf),   32'd0);
    check_val("rst data",  32'(rdata), 32'd0);

    // Single byte with a long strobe: latency k+2, one entry only
    wr    = 1'b1;
    wdata = 8'h5A;
    @(negedge clk);                       // edge k
    check_val("lat k count", 32'(count), 32'd0);
    @(negedge clk);                       // edge k+1
    check_val("lat k+1 valid", 32'(valid), 32'd0);
    @(negedge clk);                       // edge k+2
    check_val("lat k+2 count", 32'(count), 32'd1);
    check_val("lat k+2 valid", 32'(valid), 32'd1);
    check_val("lat k+2 data",  32'(rdata), 32'h5A);
    repeat (47) @(negedge clk);
    check_val("long wr count", 32'(count), 32'd1);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h5A);
    pop_expect("single pop");
    check_val("single empty count", 32'(count), 32'd0);
    check_val("single empty valid", 32'(valid), 32'd0);
    check_val("single empty data",  32'(rdata), 32'd0);

    // i_ready while empty does nothing
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_val("idle ready count", 32'(count), 32'd0);

    // Ordering and pointer wrap
    for (int i = 1; i <= 12; i++) push_byte(8'(i));
    check_val("order count12", 32'(count), 32'd12);
    for (int i = 0; i < 6; i++) pop_expect("order pop a");
    for (int i = 8'h0D; i <= 8'h16; i++) push_byte(8'(i));
    check_val("wrap count", 32'(count), 32'd16);
    check_val("wrap full",  32'(full),  32'd1);
    check_val("wrap head",  32'(rdata), 32'h07);
    for (int i = 0; i < 16; i++) pop_expect("wrap pop");
    check_val("wrap empty", 32'(count), 32'd0);
    check_val("wrap ovf",   32'(ovf),   32'd0);

    // Overflow: drop 0xEE, then clear
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    push_byte(8'hEE);
    check_val("ovf count", 32'(count), 32'd16);
    check_val("ovf flag",  32'(ovf),   32'd1);
    check_val("ovf head",  32'(rdata), 32'h20);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check_val("ovf cleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) pop_expect("ovf drain");
    check_val("ovf drained", 32'(count), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
    check_val("sim pre full", 32'(full), 32'd1);
    wr    = 1'b1;
    wdata = 8'h99;
    repeat (2) @(negedge clk);            // edges k, k+1
    check_val("sim head", 32'(rdata), 32'h30);
    ready = 1'b1;                         // pop coincides with write edge k+2
    @(negedge clk);
    ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    check_val("sim count", 32'(count), 32'd16);
    check_val("sim ovf",   32'(ovf),   32'd0);
    check_val("sim new head", 32'(rdata), 32'h31);
    wr = 1'b0;
    repeat (3) @(negedge clk);

    // Set wins over clear
    wr    = 1'b1;
    wdata = 8'hAA;
    repeat (2) @(negedge clk);
    clr_ovf = 1'b1;                       // same edge as the dropped push
    @(negedge clk);
    clr_ovf = 1'b0;
    check_val("set-over-clr ovf", 32'(ovf), 32'd1);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check_val("clr only ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) pop_expect("sim drain");
    check_val("sim drained", 32'(count), 32'd0);

    // Reset mid-operation with i_wr held high
    for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
    check_val("mid count5", 32'(count), 32'd5);
    wr    = 1'b1;
    wdata = 8'h77;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("async rst valid", 32'(valid), 32'd0);
    check_val("async rst count", 32'(count), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("held wr no entry", 32'(count), 32'd0);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    push_byte(8'h77);
    check_val("rearm count", 32'(count), 32'd1);
    pop_expect("rearm pop");
    check_val("final count", 32'(count), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
